vin_quadencoder_velocity: RTL and testbench
===========================================

VIN_QUADENCODER_VELOCITY -- requirements
Module: vin_quadencoder_velocity

Interface
REQ-001 SHALL have parameter BITS, default 32: width of the input position count.
REQ-002 SHALL have parameter VBITS, default 16: width of the signed velocity output.
REQ-003 SHALL have parameter PERIOD, default 10000: clocks per measurement gate; legal values are 2 or more.
REQ-004 SHALL have parameter STALL_GATES, default 8: number of consecutive zero-delta gates before stall is flagged; legal values are 1 or more.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port pos, input, BITS: free-running position count from the upstream quadrature decoder, treated as modulo 2^BITS.
REQ-008 SHALL have port vel, output, VBITS: signed two's-complement counts-per-gate value.
REQ-009 SHALL have port vel_valid, output, 1: vel holds a sample not yet accepted.
REQ-010 SHALL have port vel_ready, input, 1: consumer accept.
REQ-011 SHALL have port sat, output, 1: the current vel was clamped.
REQ-012 SHALL have port overrun, output, 1: sticky flag, set when at least one unaccepted sample was overwritten.
REQ-013 SHALL have port stalled, output, 1: no motion for STALL_GATES gates.

Function
REQ-014 SHALL run a gate counter 0..PERIOD-1 starting at 0 after reset, with the tick asserted in the cycle the counter equals PERIOD-1, after which the counter wraps to 0.
REQ-015 SHALL implement two states: PRIME and RUN; reset enters PRIME.
REQ-016 In PRIME, the first tick SHALL store pos as pos_prev and move to RUN, producing no output.
REQ-017 In RUN, each tick SHALL compute delta = (pos - pos_prev) mod 2^BITS, interpreted as signed BITS, and then store pos as pos_prev.
REQ-018 Wrap-around of pos SHALL yield the correct small signed delta, with no special casing.
REQ-019 Delta SHALL be clamped to [-2^(VBITS-1), 2^(VBITS-1)-1]; sat SHALL be 1 only if clamping occurred, and sat SHALL be updated together with vel.
REQ-020 Latency: with the tick at cycle T, vel, sat and vel_valid=1 SHALL be visible at T+1.
REQ-021 The transfer SHALL occur in any cycle where vel_valid and vel_ready are both 1; vel_valid SHALL fall the next cycle unless a new sample loads in that same cycle.
REQ-022 If a new sample loads while vel_valid=1 and vel_ready=0, it SHALL overwrite vel and sat, keep vel_valid=1, and set overrun=1.
REQ-023 If a tick result loads in the same cycle as an accepted transfer, it SHALL keep vel_valid=1 with the new data and SHALL NOT set overrun.
REQ-024 overrun SHALL clear on the cycle after a completed transfer, unless it is set again in that same cycle.
REQ-025 The block SHALL count consecutive RUN gates with delta==0, saturating at STALL_GATES.
REQ-026 stalled SHALL be 1 while that count equals STALL_GATES, and SHALL clear at T+1 of the first nonzero delta.
REQ-027 vel_ready SHALL have no effect while vel_valid=0.
REQ-028 pos SHALL be sampled only on tick cycles; pos changes between ticks SHALL be ignored.

Reset
REQ-029 While rst_n=0 at a clk edge, the block SHALL set vel=0, vel_valid=0, sat=0, overrun=0, stalled=0, gate counter=0, pos_prev=0, zero-gate count=0, and state=PRIME.
REQ-030 Reset mid-gate or with vel_valid=1 SHALL discard the pending sample; after release, the first output SHALL appear only after a fresh PRIME tick and a fresh RUN tick.
REQ-031 The block SHALL have no asynchronous reset path.

Verification (PERIOD=100, BITS=32, VBITS=16, STALL_GATES=8, vel_ready=1 unless stated; reset released at cycle 0)
REQ-032 Prime: pos held at 1000 -> no vel_valid through cycle 199; vel_valid=1 and vel=0 at cycle 200, for 1 cycle.
REQ-033 Steady motion: pos +37 per gate -> every output vel=37 and sat=0; pos -5 per gate -> vel=-5 (0xFFFB).
REQ-034 Wrap: pos 0xFFFFFFF0 at one tick and 0x00000010 at the next -> vel=32, sat=0.
REQ-035 Saturation: a jump of +100000 in one gate -> vel=32767, sat=1; a jump of -100000 -> vel=-32768, sat=1; the next +3 gate -> vel=3, sat=0.
REQ-036 Backpressure: vel_ready=0 across two RUN ticks -> overrun=1 and vel equals the second delta; raising vel_ready for 1 cycle -> vel_valid=0 and overrun=0 on the next cycle; a tick coinciding with the accept -> vel_valid stays 1 and overrun=0.
REQ-037 Stall and reset: pos constant for 8 RUN gates -> stalled=1; pos +1 -> stalled=0 at T+1; rst_n=0 for 1 cycle mid-gate -> all outputs 0, and the next vel_valid comes 200 cycles after release.

Source files
------------

// File: rtl/vin_quadencoder_velocity.sv
// rtl/vin_quadencoder_velocity.sv - gated position-delta velocity estimator
// Samples pos once per gate, emits a clamped signed delta with valid/ready and stall detection.
module vin_quadencoder_velocity #(
  parameter int BITS        = 32,
  parameter int VBITS       = 16,
  parameter int PERIOD      = 10000,
  parameter int STALL_GATES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BITS-1:0]  pos,
  output logic [VBITS-1:0] vel,
  output logic             vel_valid,
  input  logic             vel_ready,
  output logic             sat,
  output logic             overrun,
  output logic             stalled
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam int SW = $clog2(STALL_GATES + 1);
  localparam logic [SW-1:0] SMAX = SW'(STALL_GATES);
  localparam int W = (BITS > VBITS) ? BITS : VBITS;
  localparam logic signed [W-1:0] VMAX = $signed({{(W-VBITS+1){1'b0}}, {(VBITS-1){1'b1}}});
  localparam logic signed [W-1:0] VMIN = $signed({{(W-VBITS+1){1'b1}}, {(VBITS-1){1'b0}}});

  typedef enum logic {PRIME, RUN} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CW-1:0]     r_gate_cnt;
  logic [BITS-1:0]   r_pos_prev;
  logic [VBITS-1:0]  r_vel;
  logic              r_vel_valid;
  logic              r_sat;
  logic              r_overrun;
  logic [SW-1:0]     r_zero_cnt;

  logic              w_tick;
  logic              w_load;
  logic              w_accept;
  logic [BITS-1:0]   w_delta;
  logic signed [W-1:0] w_delta_ext;
  logic [VBITS-1:0]  w_vel_clamped;
  logic              w_sat_next;

  assign w_tick   = (r_gate_cnt == LAST);
  assign w_accept = r_vel_valid & vel_ready;

  // Modular subtraction gives the right signed delta across pos wrap-around.
  assign w_delta     = pos - r_pos_prev;
  assign w_delta_ext = W'($signed(w_delta));

  always_comb begin
    w_vel_clamped = w_delta_ext[VBITS-1:0];
    w_sat_next    = 1'b0;
    if (w_delta_ext > VMAX) begin
      w_vel_clamped = VMAX[VBITS-1:0];
      w_sat_next    = 1'b1;
    end else if (w_delta_ext < VMIN) begin
      w_vel_clamped = VMIN[VBITS-1:0];
      w_sat_next    = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      PRIME: if (w_tick) w_state_next = RUN;
      RUN:   w_load = w_tick;
      default: w_state_next = PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= PRIME;
      r_gate_cnt  <= '0;
      r_pos_prev  <= '0;
      r_vel       <= '0;
      r_vel_valid <= 1'b0;
      r_sat       <= 1'b0;
      r_overrun   <= 1'b0;
      r_zero_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_gate_cnt <= w_tick ? '0 : r_gate_cnt + 1'b1;
      if (w_tick) r_pos_prev <= pos;

      if (w_load) begin
        r_vel       <= w_vel_clamped;
        r_sat       <= w_sat_next;
        r_vel_valid <= 1'b1;
      end else if (w_accept) begin
        r_vel_valid <= 1'b0;
      end

      // A load while the old sample sits unaccepted is the only way to set overrun.
      if (w_load && r_vel_valid && !vel_ready) r_overrun <= 1'b1;
      else if (w_accept)                        r_overrun <= 1'b0;

      if (w_load) begin
        if (w_delta != '0)          r_zero_cnt <= '0;
        else if (r_zero_cnt != SMAX) r_zero_cnt <= r_zero_cnt + 1'b1;
      end
    end
  end

  assign vel       = r_vel;
  assign vel_valid = r_vel_valid;
  assign sat       = r_sat;
  assign overrun   = r_overrun;
  assign stalled   = (r_zero_cnt == SMAX);

endmodule

// File: tb/tb_vin_quadencoder_velocity.sv
// tb/tb_vin_quadencoder_velocity.sv - directed bench for vin_quadencoder_velocity
module tb_vin_quadencoder_velocity;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pos;
  logic [15:0] vel;
  logic        vel_valid;
  logic        vel_ready;
  logic        sat;
  logic        overrun;
  logic        stalled;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] p;

  vin_quadencoder_velocity #(
    .BITS(32), .VBITS(16), .PERIOD(100), .STALL_GATES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pos(pos), .vel(vel), .vel_valid(vel_valid),
    .vel_ready(vel_ready), .sat(sat), .overrun(overrun), .stalled(stalled)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // From an output-aligned cycle, present p for the whole gate and land on the next output cycle.
  task automatic run_gate(input logic [31:0] np);
    pos = np;
    step(100);
  endtask

  initial begin
    rst_n = 1'b0; pos = 32'd1000; vel_ready = 1'b1;
    step(3);
    chk("rst_vel", {16'd0, vel}, 32'd0);
    chk("rst_valid", {31'd0, vel_valid}, 32'd0);
    chk("rst_sat", {31'd0, sat}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_stalled", {31'd0, stalled}, 32'd0);
    rst_n = 1'b1;

    step(99);
    chk("prime_c99", {31'd0, vel_valid}, 32'd0);
    step(1);
    chk("prime_c100", {31'd0, vel_valid}, 32'd0);
    step(99);
    chk("prime_c199", {31'd0, vel_valid}, 32'd0);
    step(1);
    chk("prime_c200_valid", {31'd0, vel_valid}, 32'd1);
    chk("prime_c200_vel", {16'd0, vel}, 32'd0);
    step(1);
    chk("prime_c201_valid", {31'd0, vel_valid}, 32'd0);
    step(99);
    p = 32'd1000;

    for (int i = 0; i < 3; i++) begin
      p = p + 32'd37;
      run_gate(p);
      chk("plus37_vel", {16'd0, vel}, 32'd37);
      chk("plus37_sat", {31'd0, sat}, 32'd0);
      chk("plus37_valid", {31'd0, vel_valid}, 32'd1);
    end
    for (int i = 0; i < 2; i++) begin
      p = p - 32'd5;
      run_gate(p);
      chk("minus5_vel", {16'd0, vel}, 32'h0000FFFB);
    end

    run_gate(32'hFFFFFFF0);
    p = 32'h00000010;
    run_gate(p);
    chk("wrap_vel", {16'd0, vel}, 32'd32);
    chk("wrap_sat", {31'd0, sat}, 32'd0);

    p = p + 32'd100000;
    run_gate(p);
    chk("sat_pos_vel", {16'd0, vel}, 32'h00007FFF);
    chk("sat_pos_sat", {31'd0, sat}, 32'd1);
    p = p - 32'd100000;
    run_gate(p);
    chk("sat_neg_vel", {16'd0, vel}, 32'h00008000);
    chk("sat_neg_sat", {31'd0, sat}, 32'd1);
    p = p + 32'd3;
    run_gate(p);
    chk("after_sat_vel", {16'd0, vel}, 32'd3);
    chk("after_sat_sat", {31'd0, sat}, 32'd0);

    pos = 32'hDEADBEEF;
    step(50);
    p = p + 32'd7;
    pos = p;
    step(50);
    chk("ignore_between_ticks", {16'd0, vel}, 32'd7);

    step(1);
    vel_ready = 1'b0;
    p = p + 32'd11;
    pos = p;
    step(99);
    chk("bp1_valid", {31'd0, vel_valid}, 32'd1);
    chk("bp1_vel", {16'd0, vel}, 32'd11);
    chk("bp1_overrun", {31'd0, overrun}, 32'd0);
    p = p + 32'd22;
    run_gate(p);
    chk("bp2_vel", {16'd0, vel}, 32'd22);
    chk("bp2_overrun", {31'd0, overrun}, 32'd1);
    vel_ready = 1'b1;
    step(1);
    chk("accept_valid", {31'd0, vel_valid}, 32'd0);
    chk("accept_overrun", {31'd0, overrun}, 32'd0);
    vel_ready = 1'b0;
    p = p + 32'd5;
    pos = p;
    step(99);
    chk("coinc_pre_valid", {31'd0, vel_valid}, 32'd1);
    chk("coinc_pre_vel", {16'd0, vel}, 32'd5);
    p = p + 32'd6;
    pos = p;
    step(99);
    vel_ready = 1'b1;
    step(1);
    chk("coinc_valid", {31'd0, vel_valid}, 32'd1);
    chk("coinc_vel", {16'd0, vel}, 32'd6);
    chk("coinc_overrun", {31'd0, overrun}, 32'd0);
    step(1);
    chk("coinc_drain", {31'd0, vel_valid}, 32'd0);
    step(99);

    for (int i = 0; i < 6; i++) run_gate(p);
    chk("stall_7gates", {31'd0, stalled}, 32'd0);
    run_gate(p);
    chk("stall_8gates", {31'd0, stalled}, 32'd1);
    p = p + 32'd1;
    pos = p;
    step(99);
    chk("stall_at_T", {31'd0, stalled}, 32'd1);
    step(1);
    chk("stall_clear", {31'd0, stalled}, 32'd0);
    chk("stall_clear_vel", {16'd0, vel}, 32'd1);

    vel_ready = 1'b0;
    p = p + 32'd100000;
    run_gate(p);
    p = p + 32'd100000;
    run_gate(p);
    chk("pre_rst_sat", {31'd0, sat}, 32'd1);
    chk("pre_rst_overrun", {31'd0, overrun}, 32'd1);
    step(30);
    rst_n = 1'b0;
    step(1);
    chk("midrst_vel", {16'd0, vel}, 32'd0);
    chk("midrst_valid", {31'd0, vel_valid}, 32'd0);
    chk("midrst_sat", {31'd0, sat}, 32'd0);
    chk("midrst_overrun", {31'd0, overrun}, 32'd0);
    chk("midrst_stalled", {31'd0, stalled}, 32'd0);
    rst_n = 1'b1;
    vel_ready = 1'b1;
    step(199);
    chk("rerun_c199", {31'd0, vel_valid}, 32'd0);
    step(1);
    chk("rerun_c200_valid", {31'd0, vel_valid}, 32'd1);
    chk("rerun_c200_vel", {16'd0, vel}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
